// File: rtl/vid_timing_gen.sv
// vid_timing_gen: free-running 1080p60 timing + test-pattern source; define VTG_SCROLL_EN to scroll the checkerboard
module vid_timing_gen #(
    parameter int H_WIDTH  = 1920,
    parameter int H_START  = 2008,
    parameter int H_SYNC   = 44,
    parameter int H_TOTAL  = 2200,
    parameter int V_HEIGHT = 1080,
    parameter int V_START  = 1084,
    parameter int V_SYNC   = 5,
    parameter int V_TOTAL  = 1125,
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1,
    parameter int KH       = 30,
    parameter int KV       = 30
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [1:0]  pat_i,
    input  logic [23:0] solid_i,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [23:0] data_o,
    output logic        sof_o
);
    localparam int HW  = $clog2(H_TOTAL);
    localparam int VW  = $clog2(V_TOTAL);
    localparam int BW  = H_WIDTH / 8;
    localparam int BCW = $clog2(BW + 1);
    localparam int PW  = $clog2(2 * KH);
    localparam int QW  = $clog2(KV + 1);
    localparam logic [HW-1:0]  H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_ACT  = HW'(H_WIDTH);
    localparam logic [HW-1:0]  HS_BEG = HW'(H_START);
    localparam logic [HW-1:0]  HS_END = HW'(H_START + H_SYNC);
    localparam logic [VW-1:0]  V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_ACT  = VW'(V_HEIGHT);
    localparam logic [VW-1:0]  VS_BEG = VW'(V_START);
    localparam logic [VW-1:0]  VS_END = VW'(V_START + V_SYNC);
    localparam logic [BCW-1:0] B_LAST = BCW'(BW - 1);
    localparam logic [PW-1:0]  P_LAST = PW'(2 * KH - 1);
    localparam logic [PW-1:0]  P_HALF = PW'(KH);
    localparam logic [QW-1:0]  Q_LAST = QW'(KV - 1);
    localparam logic [8:0][23:0] BARS = {24'h000000, 24'h000000, 24'h0000FF, 24'hFF0000,
        24'hFF00FF, 24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};

    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [VW-1:0]  vcnt_q, vcnt_d;
    logic [1:0]     pat_q, pat_d, pat;
    logic [23:0]    solid_q, solid_d, solid;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [3:0]     bidx_q, bidx_d;
    logic [PW-1:0]  hpos_q, hpos_d, hpre;
    logic [QW-1:0]  vpos_q, vpos_d;
    logic           vph_q, vph_d;
    logic           hs_q, hs_d, vs_q, vs_d, de_q, de_d, sof_q, sof_d;
    logic [23:0]    data_q, data_d;
    logic           first, h_end, frame_end, line_start, de;
    logic [7:0]     gh, gv;
    logic [23:0]    pix;

`ifdef VTG_SCROLL_EN
    logic [PW-1:0] off_q, off_d;

    // offset advances as each frame wraps; the new value seeds the first line of the next frame
    always_comb begin
        off_d = en_i && frame_end ? (off_q == P_LAST ? '0 : off_q + 1'b1) : off_q;
        hpre = off_d;
    end

    // frame offset register, survives en_i low
    always_ff @(posedge clk_i) begin
        off_q <= rst_i ? '0 : off_d;
    end
`else
    assign hpre = '0;
`endif

    // raster counters, pattern side-counters and the registered decode of the current position
    always_comb begin
        first = hcnt_q == '0 && vcnt_q == '0;
        h_end = hcnt_q == H_LAST;
        frame_end = h_end && vcnt_q == V_LAST;
        line_start = !en_i || h_end;
        pat = first ? pat_i : pat_q;
        solid = first ? solid_i : solid_q;
        pat_d = en_i ? pat : pat_q;
        solid_d = en_i ? solid : solid_q;
        hcnt_d = line_start ? '0 : hcnt_q + 1'b1;
        vcnt_d = !en_i || frame_end ? '0 : h_end ? vcnt_q + 1'b1 : vcnt_q;
        bcnt_d = line_start || bcnt_q == B_LAST ? '0 : bcnt_q + 1'b1;
        bidx_d = line_start ? '0 : bcnt_q == B_LAST && bidx_q != 4'd8 ? bidx_q + 1'b1 : bidx_q;
        hpos_d = line_start ? hpre : hpos_q == P_LAST ? '0 : hpos_q + 1'b1;
        vpos_d = !en_i || frame_end ? '0 : !h_end ? vpos_q : vpos_q == Q_LAST ? '0 : vpos_q + 1'b1;
        vph_d = !en_i || frame_end ? 1'b0 : h_end && vpos_q == Q_LAST ? ~vph_q : vph_q;
        de = hcnt_q < H_ACT && vcnt_q < V_ACT;
        gh = 8'(hcnt_q);
        gv = 8'(vcnt_q);
        pix = pat == 2'd0 ? BARS[bidx_q] :
              pat == 2'd1 ? {gh, gv, gh + gv} :
              pat == 2'd2 ? ((hpos_q >= P_HALF) ^ vph_q ? 24'h000000 : 24'hFFFFFF) : solid;
        de_d = en_i && de;
        data_d = de_d ? pix : '0;
        hs_d = en_i && hcnt_q >= HS_BEG && hcnt_q < HS_END ? HS_POL : ~HS_POL;
        vs_d = en_i && vcnt_q >= VS_BEG && vcnt_q < VS_END ? VS_POL : ~VS_POL;
        sof_d = en_i && first;
    end

    // state and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            pat_q   <= '0;
            solid_q <= '0;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            hpos_q  <= '0;
            vpos_q  <= '0;
            vph_q   <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            vph_q   <= vph_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
        end
    end

    assign hs_o   = hs_q;
    assign vs_o   = vs_q;
    assign de_o   = de_q;
    assign data_o = data_q;
    assign sof_o  = sof_q;
endmodule

// File: tb/tb_vid_timing_gen.sv
// tb_vid_timing_gen: directed vectors plus a reference raster model for vid_timing_gen (reduced raster)
module tb_vid_timing_gen;
    localparam int HWD = 164, HST = 170, HSY = 8, HT = 184;
    localparam int VH = 40, VST = 42, VSY = 3, VT = 46;
    localparam int KH = 30, KV = 30;
    localparam int FR = HT * VT;
`ifdef VTG_SCROLL_EN
    localparam logic [23:0] C29 = 24'h000000;
`else
    localparam logic [23:0] C29 = 24'hFFFFFF;
`endif

    typedef struct {
        int frame; int h; int v;
        logic [1:0] pat; logic [23:0] sol;
        logic de; logic hs; logic vs; logic [23:0] data;
    } vec_t;

    logic clk, rst_i, en_i, hs_o, vs_o, de_o, sof_o;
    logic [1:0] pat_i;
    logic [23:0] solid_i, data_o;
    int n_assert = 0, n_fail = 0, cyc = -1, mism = 0;
    logic mon_on = 1'b0;
    vec_t vecs[$];

    vid_timing_gen #(.H_WIDTH(HWD), .H_START(HST), .H_SYNC(HSY), .H_TOTAL(HT),
        .V_HEIGHT(VH), .V_START(VST), .V_SYNC(VSY), .V_TOTAL(VT), .KH(KH), .KV(KV)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pat_i(pat_i), .solid_i(solid_i),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .data_o(data_o), .sof_o(sof_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] bar(input int h);
        logic [23:0] tbl [8];
        tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return h / (HWD / 8) >= 8 ? 24'h0 : tbl[h / (HWD / 8)];
    endfunction

    // reference model: division-based decode of the raster position, one clock behind the inputs
    int mpos = 0, moff = 0, mh, mv;
    logic [1:0] mpat;
    logic [23:0] msol, e_data;
    logic e_hs, e_vs, e_de, e_sof;
    always @(posedge clk) begin
        if (rst_i || !en_i) begin
            if (rst_i) begin mpat = 0; msol = 0; moff = 0; end
            mpos = 0; e_hs = 0; e_vs = 0; e_de = 0; e_sof = 0; e_data = 0;
        end else begin
            mh = mpos % HT;
            mv = mpos / HT;
            if (mpos == 0) begin mpat = pat_i; msol = solid_i; end
            e_de = mh < HWD && mv < VH;
            e_hs = mh >= HST && mh < HST + HSY;
            e_vs = mv >= VST && mv < VST + VSY;
            e_sof = mpos == 0;
            e_data = !e_de ? 24'h0 : mpat == 0 ? bar(mh) :
                     mpat == 1 ? {8'(mh), 8'(mv), 8'(mh + mv)} :
                     mpat == 2 ? (((((mh + moff) / KH) ^ (mv / KV)) & 1) != 0 ? 24'h0 : 24'hFFFFFF) : msol;
            mpos++;
            if (mpos == FR) begin
                mpos = 0;
`ifdef VTG_SCROLL_EN
                moff = (moff + 1) % (2 * KH);
`endif
            end
        end
    end

    int first_t;
    logic [28:0] first_act, first_exp;
    always @(negedge clk) begin
        if (mon_on && {hs_o, vs_o, de_o, sof_o, data_o} !== {e_hs, e_vs, e_de, e_sof, e_data}) begin
            mism++;
            if (mism == 1) begin
                first_t = int'($time);
                first_act = {hs_o, vs_o, de_o, sof_o, data_o};
                first_exp = {e_hs, e_vs, e_de, e_sof, e_data};
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic adv(input int t);
        while (cyc < t) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int de_c, hs_c, vs_c, sof_c, blank_nz, solid_bad;

    initial begin
        // frame, h, v, pat, solid, de, hs, vs, data
        vecs.push_back('{0,   0,  0, 2'd0, 24'h0, 1, 0, 0, 24'hFFFFFF});
        vecs.push_back('{0,  19,  0, 2'd0, 24'h0, 1, 0, 0, 24'hFFFFFF});
        vecs.push_back('{0,  20,  0, 2'd0, 24'h0, 1, 0, 0, 24'hFFFF00});
        vecs.push_back('{0,  39,  0, 2'd0, 24'h0, 1, 0, 0, 24'hFFFF00});
        vecs.push_back('{0,  40,  0, 2'd0, 24'h0, 1, 0, 0, 24'h00FFFF});
        vecs.push_back('{0, 140,  0, 2'd0, 24'h0, 1, 0, 0, 24'h000000});
        vecs.push_back('{0, 163,  0, 2'd0, 24'h0, 1, 0, 0, 24'h000000});
        vecs.push_back('{0, 164,  0, 2'd0, 24'h0, 0, 0, 0, 24'h000000});
        vecs.push_back('{0, 170,  0, 2'd0, 24'h0, 0, 1, 0, 24'h000000});
        vecs.push_back('{0, 177,  0, 2'd0, 24'h0, 0, 1, 0, 24'h000000});
        vecs.push_back('{0, 178,  0, 2'd0, 24'h0, 0, 0, 0, 24'h000000});
        vecs.push_back('{0, 100, 39, 2'd0, 24'h0, 1, 0, 0, 24'hFF0000});
        vecs.push_back('{0,   0, 40, 2'd0, 24'h0, 0, 0, 0, 24'h000000});
        vecs.push_back('{0,   5, 42, 2'd2, 24'h0, 0, 0, 1, 24'h000000});
        vecs.push_back('{0, 183, 44, 2'd2, 24'h0, 0, 0, 1, 24'h000000});
        vecs.push_back('{0,   0, 45, 2'd2, 24'h0, 0, 0, 0, 24'h000000});
        vecs.push_back('{1,   0,  0, 2'd2, 24'h0, 1, 0, 0, 24'hFFFFFF});
        vecs.push_back('{1,  29,  0, 2'd2, 24'h0, 1, 0, 0, C29});
        vecs.push_back('{1,  30,  0, 2'd2, 24'h0, 1, 0, 0, 24'h000000});
        vecs.push_back('{1,  90,  0, 2'd2, 24'h0, 1, 0, 0, 24'h000000});
        vecs.push_back('{1,  60, 29, 2'd2, 24'h0, 1, 0, 0, 24'hFFFFFF});
        vecs.push_back('{1,   0, 30, 2'd2, 24'h0, 1, 0, 0, 24'h000000});
        vecs.push_back('{1,  30, 30, 2'd2, 24'h0, 1, 0, 0, 24'hFFFFFF});
        vecs.push_back('{1,  10, 35, 2'd1, 24'h0, 1, 0, 0, 24'h000000});
        vecs.push_back('{1,  40, 36, 2'd1, 24'h0, 1, 0, 0, 24'hFFFFFF});
        vecs.push_back('{2,   0,  0, 2'd1, 24'h0, 1, 0, 0, 24'h000000});
        vecs.push_back('{2, 150, 10, 2'd1, 24'h0, 1, 0, 0, 24'h960AA0});
        vecs.push_back('{2, 170, 10, 2'd1, 24'h0, 0, 1, 0, 24'h000000});
        vecs.push_back('{2, 130, 35, 2'd3, 24'h123456, 1, 0, 0, 24'h8223A5});
        vecs.push_back('{3,   0,  0, 2'd3, 24'h123456, 1, 0, 0, 24'h123456});
        vecs.push_back('{3, 163, 39, 2'd3, 24'h123456, 1, 0, 0, 24'h123456});
        vecs.push_back('{3, 164, 39, 2'd3, 24'h123456, 0, 0, 0, 24'h000000});

        rst_i = 1'b1; en_i = 1'b0; pat_i = 2'd0; solid_i = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        mon_on = 1'b1;
        chk("reset_hs", hs_o, 0);
        chk("reset_vs", vs_o, 0);
        chk("reset_de", de_o, 0);
        chk("reset_data", data_o, 0);
        chk("reset_sof", sof_o, 0);
        rst_i = 1'b0;
        tick();
        tick();
        chk("en_low_de", de_o, 0);
        chk("en_low_sof", sof_o, 0);

        en_i = 1'b1;
        cyc = -1;
        foreach (vecs[i]) begin
            pat_i = vecs[i].pat;
            solid_i = vecs[i].sol;
            adv(vecs[i].frame * FR + vecs[i].v * HT + vecs[i].h);
            chk($sformatf("vec%0d_de", i), de_o, vecs[i].de);
            chk($sformatf("vec%0d_hs", i), hs_o, vecs[i].hs);
            chk($sformatf("vec%0d_vs", i), vs_o, vecs[i].vs);
            chk($sformatf("vec%0d_sof", i), sof_o, vecs[i].h == 0 && vecs[i].v == 0);
            chk($sformatf("vec%0d_data", i), data_o, vecs[i].data);
        end

        // one whole frame of solid colour: signal durations and frame length
        de_c = 0; hs_c = 0; vs_c = 0; sof_c = 0; blank_nz = 0; solid_bad = 0;
        for (int k = 0; k < FR; k++) begin
            adv(4 * FR + k);
            de_c += de_o; hs_c += hs_o; vs_c += vs_o; sof_c += sof_o;
            blank_nz += (!de_o && data_o != 0);
            solid_bad += (de_o && data_o != 24'h123456);
        end
        chk("frame_de_clocks", de_c, HWD * VH);
        chk("frame_hs_clocks", hs_c, HSY * VT);
        chk("frame_vs_clocks", vs_c, VSY * HT);
        chk("frame_sof_count", sof_c, 1);
        chk("frame_blank_data", blank_nz, 0);
        chk("frame_solid_data", solid_bad, 0);
        adv(5 * FR);
        chk("frame_len_sof", sof_o, 1);

        // enable drop inside the sync region, then restart
        adv(5 * FR + 43 * HT + 172);
        chk("pre_drop_hs", hs_o, 1);
        chk("pre_drop_vs", vs_o, 1);
        en_i = 1'b0;
        tick();
        chk("drop_hs", hs_o, 0);
        chk("drop_vs", vs_o, 0);
        chk("drop_de", de_o, 0);
        tick();
        tick();
        chk("drop_sof", sof_o, 0);
        en_i = 1'b1;
        cyc = -1;
        adv(0);
        chk("restart_sof", sof_o, 1);
        chk("restart_de", de_o, 1);
        chk("restart_data", data_o, 24'h123456);
        adv(1);
        chk("restart_sof_single", sof_o, 0);

        // mid-frame reset held for three clocks
        pat_i = 2'd0;
        adv(20 * HT + 99);
        chk("pre_rst_data", data_o, 24'h123456);
        rst_i = 1'b1;
        tick();
        chk("rst1_de", de_o, 0);
        chk("rst1_data", data_o, 0);
        chk("rst1_hs", hs_o, 0);
        chk("rst1_vs", vs_o, 0);
        tick();
        tick();
        chk("rst3_de", de_o, 0);
        rst_i = 1'b0;
        cyc = -1;
        adv(0);
        chk("post_rst_sof", sof_o, 1);
        chk("post_rst_data", data_o, 24'hFFFFFF);
        adv(20);
        chk("post_rst_bar1", data_o, 24'hFFFF00);
        adv(HT);
        chk("post_rst_line1_sof", sof_o, 0);
        chk("post_rst_line1_data", data_o, 24'hFFFFFF);

        n_assert++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL model_trace: %0d cycles differ, first at t=%0d got %h expected %h",
                     mism, first_t, first_act, first_exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
